// File: rtl/alu_exec_stage.sv
// alu_exec_stage
// Execute-stage ALU with a valid/ready input handshake and a 2-entry result
// queue toward the memory/writeback stage.
//
// Ports:
//   clk        system clock, everything on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream presents an operation
//   in_ready   stage can accept an operation this cycle
//   alu_ctrl   4-bit ALU control code from the ALU control decoder
//   operand_a  first operand (rs)
//   operand_b  second operand (rt/imm)
//   out_valid  head queue entry is valid
//   out_ready  downstream takes the head entry this cycle
//   result     head entry result (0 when out_valid=0)
//   zero       head entry result == 0
//   overflow   head entry signed overflow (ADD/SUB only)
//   illegal    head entry had an unsupported alu_ctrl
//   op_count   saturating count of popped entries
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Queue storage, one slot per pointer value
  logic [1:0][WIDTH-1:0] res_q, res_d;
  logic [1:0]            zero_q, zero_d;
  logic [1:0]            ovf_q, ovf_d;
  logic [1:0]            ill_q, ill_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic [CNT_W-1:0]      op_count_q, op_count_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             push;
  logic             pop;

  // Operation decode and datapath for the operation presented this cycle
  always_comb begin
    alu_res = {WIDTH{1'b0}};
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (alu_ctrl)
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_ADD: begin
        alu_res = operand_a + operand_b;
        alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = operand_a - operand_b;
        alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand_a[WIDTH-1]);
      end
      // True signed compare; the subtract sign bit is wrong on overflow.
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_NOR: alu_res = ~(operand_a | operand_b);
      default: alu_ill = 1'b1;
    endcase
  end

  // Handshake: in_ready depends only on registered occupancy (and rst)
  always_comb begin
    in_ready  = (count_q != 2'd2) & ~rst;
    out_valid = (count_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next-state for queue slots, pointers, occupancy and the pop counter
  always_comb begin
    res_d      = res_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    ill_d      = ill_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    op_count_d = op_count_q;

    if (push) begin
      res_d[wr_ptr_q]  = alu_res;
      zero_d[wr_ptr_q] = (alu_res == {WIDTH{1'b0}});
      ovf_d[wr_ptr_q]  = alu_ovf;
      ill_d[wr_ptr_q]  = alu_ill;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (op_count_q != CNT_MAX) begin
        op_count_d = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        op_count_d = op_count_q;
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q      <= '0;
      zero_q     <= 2'b00;
      ovf_q      <= 2'b00;
      ill_q      <= 2'b00;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      op_count_q <= {CNT_W{1'b0}};
    end else begin
      res_q      <= res_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      ill_q      <= ill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      op_count_q <= op_count_d;
    end
  end

  // Head entry outputs, forced to zero while the queue is empty
  always_comb begin
    if (out_valid) begin
      result   = res_q[rd_ptr_q];
      zero     = zero_q[rd_ptr_q];
      overflow = ovf_q[rd_ptr_q];
      illegal  = ill_q[rd_ptr_q];
    end else begin
      result   = {WIDTH{1'b0}};
      zero     = 1'b0;
      overflow = 1'b0;
      illegal  = 1'b0;
    end
    op_count = op_count_q;
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage ALU consuming the 4-bit ALU control code produced by the ALU control decoder, together with two operands.
- Accepts operations over a valid/ready handshake and computes the result in the accept cycle.
- Buffers up to two results in a 2-entry output queue, with flags, until the downstream (memory/writeback) stage takes them.
- Keeps a saturating count of completed operations for debug.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)
CNT_W, 16, width of completed-operation counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents an operation
in_ready  output  1  stage can accept an operation this cycle
alu_ctrl  input  4  ALU control code
operand_a  input  WIDTH  first operand (rs)
operand_b  input  WIDTH  second operand (rt/imm)
out_valid  output  1  head result entry is valid
out_ready  input  1  downstream takes head entry this cycle
result  output  WIDTH  head entry result
zero  output  1  head entry result == 0
overflow  output  1  head entry signed overflow (ADD/SUB only)
illegal  output  1  head entry had unsupported alu_ctrl
op_count  output  CNT_W  number of popped entries, saturating

Behaviour:
- Reset: one clk and rst are decided; rst is synchronous and active-high. While rst is high at a rising edge:
  - queue emptied; count=0; rd/wr pointers=0
  - out_valid=0, result=0, zero=0, overflow=0, illegal=0, op_count=0
  - in_ready=0 during the reset cycle; in_ready=1 from the first edge after rst deasserts
  - rst mid-operation discards all buffered entries; no pop is counted in that cycle
- Handshake:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_valid/operands need not be held after acceptance
  - head entry and its flags hold stable while out_valid=1 and out_ready=0
- Queue:
  - 2 entries, each = {result, zero, overflow, illegal}
  - out_valid = (count != 0); in_ready = (count != 2) & ~rst
  - in_ready depends only on registered state: when full, no push in the same cycle as a pop; the pop frees a slot for the next cycle
  - push & pop simultaneously with count=1: count stays 1; head advances to the new entry
  - push & pop with count=0 is impossible, since out_valid=0
  - pointers are 1-bit and wrap 1->0
  - When out_valid=0, result/flags drive 0
- Latency: an operation accepted at edge N is visible on result at edge N (registered) if the queue was empty, i.e. out_valid=1 in the cycle after acceptance. Throughput: 1 op/cycle when out_ready is held high.
- Operation decode (WIDTH-bit, wrap-around modulo 2^WIDTH):
  - 0000 AND: a & b
  - 0001 OR: a | b
  - 0010 ADD: a + b; overflow = a,b same sign and result sign differs
  - 0110 SUB: a - b; overflow = a,b signs differ and result sign != a sign
  - 0111 SLT: result = 1 if $signed(a) < $signed(b), else 0. Computed by true signed compare, not by the subtract sign bit.
  - 1100 NOR: ~(a | b)
  - any other code: result=0, illegal=1, zero=1, overflow=0
- overflow=0 for all ops except ADD/SUB.
- zero is computed from the stored result.
- op_count increments by 1 on each pop and saturates at 2^CNT_W-1 (no wrap).

Test Plan:
- Reset/idle: hold rst 2 cycles -> out_valid=0, result=0, op_count=0, in_ready=0 during rst; in_ready=1 first cycle after.
- Op sweep with out_ready=1, a=0x0000000C, b=0x0000000A, push codes 0000,0001,0010,0110,0111,1100 back-to-back -> results 0x8, 0xE, 0x16, 0x2, 0x0 (zero=1), 0xFFFFFFF1, in order, one per cycle; op_count=6.
- Overflow/sign: ADD 0x7FFFFFFF+0x1 -> 0x80000000, overflow=1. SUB 0x80000000-0x1 -> 0x7FFFFFFF, overflow=1. SLT a=0xFFFFFFFF, b=0x1 -> 1. SLT a=0x80000000, b=0x7FFFFFFF -> 1 with overflow=0.
- Backpressure: out_ready=0, push ADD 1+2 then ADD 3+4 -> in_ready=0 after second accept; a third in_valid is not accepted; result stays 3. Raise out_ready one cycle -> result=7; in_ready=1 next cycle; op_count=1.
- Illegal code: alu_ctrl=4'b1111 -> result=0, illegal=1, zero=1, overflow=0. Next legal entry has illegal=0.
- Reset mid-operation: queue holds 2 entries with out_ready=0; assert rst 1 cycle -> out_valid=0, op_count=0. Post-reset push AND 0xF0&0x3C -> result=0x30.
